// File: rtl/eth_rx_mac_filter.sv
// ---------------------------------------------------------------------------
// eth_rx_mac_filter
//
// Serial Ethernet frame receiver with a destination-MAC filter. Bytes arrive
// LSB first on a SPI-style link (sck/sda/n_ss). Each completed byte is
// presented on d/a with a one-clock active-low write strobe for an external
// frame buffer. The first six bytes (destination MAC) are compared against
// the station address and broadcast. A frame that matches neither is
// inhibited for the rest of its duration.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous reset, active high
//   sck        in   serial bit clock (asynchronous to clk), data valid on rise
//   sda        in   serial data, LSB of each byte first
//   n_ss       in   frame select, active low for the whole frame
//   d          out  received byte for the buffer
//   a          out  byte address within the frame (0 = first byte)
//   n_we       out  buffer write strobe, active low, one clk wide
//   n_cs       out  buffer chip select, active low while a frame is active
//   n_inhibit  out  low = frame rejected by the MAC filter
// ---------------------------------------------------------------------------
module eth_rx_mac_filter #(
  parameter logic [47:0] MAC         = 48'hFEFAF6F2EEEA,
  parameter int          ADDR_W      = 11,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              sda,
  input  logic              n_ss,
  output logic [7:0]        d,
  output logic [ADDR_W-1:0] a,
  output logic              n_we,
  output logic              n_cs,
  output logic              n_inhibit
);

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] A_MAX = '1;

  // Destination-MAC byte k as it appears on the wire (byte 0 first).
  function automatic logic [7:0] mac_byte(input logic [ADDR_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (int'(idx) == k) r = MAC[47-8*k -: 8];
    end
    return r;
  endfunction

  // Address increment that sticks at the top of the buffer.
  function automatic logic [ADDR_W-1:0] addr_sat_inc(input logic [ADDR_W-1:0] x);
    return (x == A_MAX) ? x : x + 1'b1;
  endfunction

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, sda_sync, nss_sync;
  logic sck_s, sda_s, nss_s;
  logic sck_prev, nss_prev;
  logic sck_rise, nss_rise, nss_fall;

  logic       in_frame, bit_stb, byte_done, frame_end, rejected;
  logic [2:0] bit_cnt;
  logic [7:0] shift, byte_nxt;
  logic       match_own, match_bcast;
  logic       full;
  logic       end_pend;

  // --- input synchronizers and edge detection ---
  // These flops carry no reset: the edge detectors keep tracking the pins
  // through reset, so an n_ss already low when reset releases is not seen
  // as a falling edge.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
    nss_sync <= {nss_sync[SYNC_STAGES-2:0], n_ss};
    sck_prev <= sck_s;
    nss_prev <= nss_s;
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign nss_s    = nss_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign nss_rise = nss_s & ~nss_prev;
  assign nss_fall = ~nss_s & nss_prev;

  assign in_frame  = (state == FRAME);
  assign bit_stb   = in_frame & sck_rise;
  assign byte_done = bit_stb & (bit_cnt == 3'd7);
  assign byte_nxt  = {sda_s, shift[7:1]};
  assign rejected  = ~match_own & ~match_bcast;

  // When the last bit and the n_ss rise land together, the byte's write is
  // let through first and the frame is closed one clock later via end_pend.
  assign frame_end = in_frame & (end_pend | (nss_rise & ~byte_done));

  // --- frame FSM ---
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (nss_fall)  state_nxt = FRAME;
      FRAME:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --- byte assembly, filter and buffer interface ---
  always_ff @(posedge clk) begin
    if (rst) begin
      d           <= 8'h00;
      a           <= '0;
      n_we        <= 1'b1;
      n_cs        <= 1'b1;
      n_inhibit   <= 1'b1;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      match_own   <= 1'b0;
      match_bcast <= 1'b0;
      full        <= 1'b0;
      end_pend    <= 1'b0;
    end else begin
      n_we <= 1'b1;

      // Retire the write strobe: advance the address unless the frame was
      // just rejected. Writing the last address marks the buffer full so
      // later bytes are dropped.
      if (!n_we && !rejected && !full) begin
        a <= addr_sat_inc(a);
        if (a == A_MAX) full <= 1'b1;
      end

      if (state == IDLE) begin
        if (nss_fall) begin
          a           <= '0;
          bit_cnt     <= 3'd0;
          match_own   <= 1'b1;
          match_bcast <= 1'b1;
          full        <= 1'b0;
          n_cs        <= 1'b0;
        end
      end else begin
        if (bit_stb) begin
          shift   <= byte_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end

        if (byte_done) begin
          d <= byte_nxt;
          if (n_inhibit && !full) n_we <= 1'b0;
          // The address equals the byte index while the MAC is arriving.
          if (int'(a) < 6) begin
            match_own   <= match_own & (byte_nxt == mac_byte(a));
            match_bcast <= match_bcast & (byte_nxt == 8'hFF);
          end
          if (nss_rise) end_pend <= 1'b1;
        end

        if (rejected) n_inhibit <= 1'b0;

        if (frame_end) begin
          n_cs      <= 1'b1;
          n_inhibit <= 1'b1;
          bit_cnt   <= 3'd0;
          end_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_mac_filter
//
// Directed bench for eth_rx_mac_filter: own-MAC, broadcast and mismatching
// frames, inhibit release, partial bytes and mid-frame reset. A monitor
// records every buffer write; each test task compares against values it
// computes from its own stimulus.
// ---------------------------------------------------------------------------
module tb_eth_rx_mac_filter;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              sck;
  logic              sda;
  logic              n_ss;
  logic [7:0]        d;
  logic [ADDR_W-1:0] a;
  logic              n_we;
  logic              n_cs;
  logic              n_inhibit;

  int tests = 0;
  int fails = 0;

  eth_rx_mac_filter #(
    .MAC        (48'hFEFAF6F2EEEA),
    .ADDR_W     (ADDR_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .sda      (sda),
    .n_ss     (n_ss),
    .d        (d),
    .a        (a),
    .n_we     (n_we),
    .n_cs     (n_cs),
    .n_inhibit(n_inhibit)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  int                wr_cnt     = 0;
  int                inh_cnt    = 0;
  int                bad_we_cnt = 0;
  logic [7:0]        wr_d [256];
  logic [ADDR_W-1:0] wr_a [256];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (n_we === 1'b0) begin
        wr_d[wr_cnt % 256] = d;
        wr_a[wr_cnt % 256] = a;
        wr_cnt = wr_cnt + 1;
        if (n_inhibit !== 1'b1 || n_cs !== 1'b0) bad_we_cnt = bad_we_cnt + 1;
      end
      if (n_inhibit === 1'b0) inh_cnt = inh_cnt + 1;
    end
  end

  logic [7:0] fb [32];

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sda = b[i];
      sck = 1'b0;
      #40;
      sck = 1'b1;
      #40;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda = b[i];
      sck = 1'b0;
      #40;
      sck = 1'b1;
      #40;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    sck  = 1'b0;
    n_ss = 1'b0;
    #80;
  endtask

  task automatic end_frame();
    sck = 1'b0;
    #80;
    n_ss = 1'b1;
  endtask

  task automatic load_own(input int payload);
    fb[0] = 8'hFE; fb[1] = 8'hFA; fb[2] = 8'hF6;
    fb[3] = 8'hF2; fb[4] = 8'hEE; fb[5] = 8'hEA;
    for (int i = 6; i < 6 + payload; i++) fb[i] = (i % 2 == 0) ? 8'h77 : 8'h88;
  endtask

  // Checks that n writes landed at addresses 0..n-1 carrying fb[0..n-1].
  task automatic check_writes(input string tag, input int base, input int n);
    tests++;
    if (wr_cnt - base !== n) begin
      fails++;
      $display("FAIL %s write_count got %0d want %0d", tag, wr_cnt - base, n);
    end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (wr_a[(base + i) % 256] !== ADDR_W'(i) || wr_d[(base + i) % 256] !== fb[i]) begin
        fails++;
        $display("FAIL %s write[%0d] got a=%0d d=%02h want a=%0d d=%02h", tag, i,
                 wr_a[(base + i) % 256], wr_d[(base + i) % 256], i, fb[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sck  = 1'b0;
    sda  = 1'b0;
    n_ss = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (d !== 8'h00)     begin fails++; $display("FAIL reset_d got %02h want 00", d); end
    tests++; if (a !== '0)        begin fails++; $display("FAIL reset_a got %0d want 0", a); end
    tests++; if (n_we !== 1'b1)   begin fails++; $display("FAIL reset_n_we got %b want 1", n_we); end
    tests++; if (n_cs !== 1'b1)   begin fails++; $display("FAIL reset_n_cs got %b want 1", n_cs); end
    tests++; if (n_inhibit !== 1'b1) begin fails++; $display("FAIL reset_n_inhibit got %b want 1", n_inhibit); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_own_mac();
    int base, ibase, bbase;
    load_own(14);
    base = wr_cnt; ibase = inh_cnt; bbase = bad_we_cnt;
    start_frame();
    for (int i = 0; i < 20; i++) send_byte(fb[i]);
    tests++; if (n_cs !== 1'b0) begin fails++; $display("FAIL own_cs_active got %b want 0", n_cs); end
    end_frame();
    #100;
    check_writes("own", base, 20);
    tests++; if (inh_cnt - ibase !== 0) begin fails++; $display("FAIL own_inhibit_cycles got %0d want 0", inh_cnt - ibase); end
    tests++; if (bad_we_cnt - bbase !== 0) begin fails++; $display("FAIL own_bad_we got %0d want 0", bad_we_cnt - bbase); end
    tests++; if (n_cs !== 1'b1) begin fails++; $display("FAIL own_cs_release got %b want 1", n_cs); end
  endtask

  task automatic test_broadcast();
    int base, ibase;
    load_own(14);
    for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
    base = wr_cnt; ibase = inh_cnt;
    start_frame();
    for (int i = 0; i < 20; i++) send_byte(fb[i]);
    end_frame();
    #100;
    check_writes("bcast", base, 20);
    tests++; if (inh_cnt - ibase !== 0) begin fails++; $display("FAIL bcast_inhibit_cycles got %0d want 0", inh_cnt - ibase); end
  endtask

  task automatic test_mismatch_byte1();
    int base, bbase;
    load_own(6);
    fb[1] = 8'hDA;
    base = wr_cnt; bbase = bad_we_cnt;
    start_frame();
    for (int i = 0; i < 12; i++) send_byte(fb[i]);
    tests++; if (n_inhibit !== 1'b0) begin fails++; $display("FAIL mm1_inhibit got %b want 0", n_inhibit); end
    end_frame();
    #100;
    // Bytes 0 and 1 are written before the inhibit takes hold; none after.
    check_writes("mm1", base, 2);
    tests++; if (bad_we_cnt - bbase !== 0) begin fails++; $display("FAIL mm1_we_while_inhibit got %0d want 0", bad_we_cnt - bbase); end
    tests++; if (n_inhibit !== 1'b1) begin fails++; $display("FAIL mm1_release_100ns got %b want 1", n_inhibit); end
    tests++; if (n_cs !== 1'b1) begin fails++; $display("FAIL mm1_cs_release got %b want 1", n_cs); end
  endtask

  task automatic test_mismatch_recover();
    int base, ibase;
    load_own(2);
    fb[1] = 8'hDA;
    fb[4] = 8'hEA;
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(fb[i]);
    tests++; if (n_inhibit !== 1'b0) begin fails++; $display("FAIL mm4_inhibit got %b want 0", n_inhibit); end
    end_frame();
    #100;
    tests++; if (n_inhibit !== 1'b1) begin fails++; $display("FAIL mm4_release got %b want 1", n_inhibit); end
    load_own(2);
    base = wr_cnt; ibase = inh_cnt;
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(fb[i]);
    end_frame();
    #100;
    check_writes("recover", base, 8);
    tests++; if (inh_cnt - ibase !== 0) begin fails++; $display("FAIL recover_inhibit_cycles got %0d want 0", inh_cnt - ibase); end
  endtask

  task automatic test_mismatch_byte2();
    int base;
    load_own(0);
    fb[2] = 8'hF7;
    base = wr_cnt;
    start_frame();
    for (int i = 0; i < 3; i++) send_byte(fb[i]);
    #40;
    tests++; if (n_inhibit !== 1'b0) begin fails++; $display("FAIL mm2_inhibit got %b want 0", n_inhibit); end
    for (int i = 3; i < 6; i++) send_byte(fb[i]);
    end_frame();
    #100;
    check_writes("mm2", base, 3);
    tests++; if (n_inhibit !== 1'b1) begin fails++; $display("FAIL mm2_release got %b want 1", n_inhibit); end
  endtask

  task automatic test_partial_and_reset();
    int base;
    load_own(0);
    base = wr_cnt;
    start_frame();
    send_byte(fb[0]);
    send_bits(8'h1F, 5);
    end_frame();
    #100;
    check_writes("partial", base, 1);
    tests++; if (n_cs !== 1'b1) begin fails++; $display("FAIL partial_cs got %b want 1", n_cs); end

    start_frame();
    send_byte(fb[0]);
    send_byte(fb[1]);
    send_bits(8'h03, 3);
    tests++; if (n_cs !== 1'b0) begin fails++; $display("FAIL abort_cs_before got %b want 0", n_cs); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (d !== 8'h00)        begin fails++; $display("FAIL abort_d got %02h want 00", d); end
    tests++; if (a !== '0)           begin fails++; $display("FAIL abort_a got %0d want 0", a); end
    tests++; if (n_we !== 1'b1)      begin fails++; $display("FAIL abort_n_we got %b want 1", n_we); end
    tests++; if (n_cs !== 1'b1)      begin fails++; $display("FAIL abort_n_cs got %b want 1", n_cs); end
    tests++; if (n_inhibit !== 1'b1) begin fails++; $display("FAIL abort_n_inhibit got %b want 1", n_inhibit); end
    rst = 1'b0;
    // n_ss is still low: no frame may start without a fresh falling edge.
    base = wr_cnt;
    #80;
    send_byte(8'hFE);
    send_byte(8'hFA);
    tests++; if (n_cs !== 1'b1) begin fails++; $display("FAIL no_start_cs got %b want 1", n_cs); end
    tests++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL no_start_writes got %0d want 0", wr_cnt - base); end
    end_frame();
    #100;
  endtask

  initial begin
    test_reset();
    test_own_mac();
    test_broadcast();
    test_mismatch_byte1();
    test_mismatch_recover();
    test_mismatch_byte2();
    test_partial_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
